// File: rtl/sad_stream_engine_if.sv
// Pixel-stream and result bundle for sad_stream_engine.
// master = pixel fetch / search controller side, slave = the engine.
interface sad_stream_engine_if #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 16,
  parameter int BEATS  = 16,
  parameter int IDXW   = 8
);
  localparam int SWIDTH = DWIDTH + $clog2(LANES * BEATS);
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LANES*DWIDTH-1:0] din;
  logic [LANES*DWIDTH-1:0] refi;
  logic                    in_vld;
  logic                    srch_last;
  logic                    cal_clr;
  logic [SWIDTH-1:0]       sad;
  logic                    sad_vld;
  logic [BCW-1:0]          beat_cnt;
  logic [SWIDTH-1:0]       min_sad;
  logic [IDXW-1:0]         min_idx;
  logic                    min_vld;

  modport master (
    output din, refi, in_vld, srch_last, cal_clr,
    input  sad, sad_vld, beat_cnt, min_sad, min_idx, min_vld
  );

  modport slave (
    input  din, refi, in_vld, srch_last, cal_clr,
    output sad, sad_vld, beat_cnt, min_sad, min_idx, min_vld
  );
endinterface

// File: rtl/sad_stream_engine.sv
// Streaming SAD engine: |din-refi| per lane, registered adder tree, per-block accumulator.
// Optional minimum-SAD search tracker enabled by defining SAD_MIN_TRACK_EN.
module sad_stream_engine #(
  parameter int DWIDTH    = 8,
  parameter int LANES     = 16,
  parameter int BEATS     = 16,
  parameter int IDXW      = 8,
  parameter int OUT_DELAY = 0
) (
  input logic                clk,
  input logic                rstn,
  sad_stream_engine_if.slave bus
);
  localparam int SWIDTH = DWIDTH + $clog2(LANES * BEATS);
  localparam int LOG2L  = $clog2(LANES);
  localparam int TW     = DWIDTH + LOG2L;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BCW-1:0]          beat_cnt;
  logic                    accept, is_first, is_last;
  logic signed [DWIDTH:0]  diff    [LANES];
  logic [DWIDTH-1:0]       abs_now [LANES];
  logic [DWIDTH-1:0]       s1_abs  [LANES];
  logic                    s1_vld, s1_first, s1_last;
  logic [TW-1:0]           lvl     [LOG2L+1][LANES];
  logic [TW-1:0]           s2_sum;
  logic                    s2_vld, s2_first, s2_last;
  logic [SWIDTH-1:0]       acc;
  logic                    s3_done;
  logic [SWIDTH-1:0]       o_sad   [OUT_DELAY+1];
  logic                    o_vld   [OUT_DELAY+1];

  assign accept   = bus.in_vld && !bus.cal_clr;
  assign is_first = (beat_cnt == '0);
  assign is_last  = (beat_cnt == BCW'(BEATS - 1));

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      diff[k]    = $signed({1'b0, bus.din[k*DWIDTH +: DWIDTH]})
                 - $signed({1'b0, bus.refi[k*DWIDTH +: DWIDTH]});
      abs_now[k] = diff[k][DWIDTH] ? DWIDTH'(-diff[k]) : DWIDTH'(diff[k]);
    end
  end

  // Beat counter and S1: cal_clr drops the incoming beat and restarts the block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_abs   <= '{default: '0};
    end else begin
      s1_vld <= accept;
      if (bus.cal_clr)
        beat_cnt <= '0;
      else if (bus.in_vld)
        beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
      if (accept) begin
        s1_abs   <= abs_now;
        s1_first <= is_first;
        s1_last  <= is_last;
      end
    end
  end

  // Level 0 holds zero-extended lane values; each level halves the operand count.
  always_comb begin
    lvl = '{default: '0};
    for (int k = 0; k < LANES; k++)
      lvl[0][k] = TW'(s1_abs[k]);
    for (int l = 1; l <= LOG2L; l++)
      for (int k = 0; k < (LANES >> l); k++)
        lvl[l][k] = lvl[l-1][2*k] + lvl[l-1][2*k+1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_sum   <= '0;
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_sum   <= lvl[LOG2L][0];
      s2_vld   <= s1_vld && !bus.cal_clr;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // S3 accumulator; a completed total sits in acc for one cycle while s3_done is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc     <= '0;
      s3_done <= 1'b0;
    end else if (bus.cal_clr) begin
      acc     <= '0;
      s3_done <= 1'b0;
    end else begin
      s3_done <= s2_vld && s2_last;
      if (s2_vld)
        acc <= s2_first ? SWIDTH'(s2_sum) : acc + SWIDTH'(s2_sum);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_sad <= '{default: '0};
      o_vld <= '{default: 1'b0};
    end else begin
      o_vld[0] <= s3_done;
      if (s3_done)
        o_sad[0] <= acc;
      for (int i = 1; i <= OUT_DELAY; i++) begin
        o_vld[i] <= o_vld[i-1];
        o_sad[i] <= o_sad[i-1];
      end
    end
  end

  assign bus.sad      = o_sad[OUT_DELAY];
  assign bus.sad_vld  = o_vld[OUT_DELAY];
  assign bus.beat_cnt = beat_cnt;

`ifdef SAD_MIN_TRACK_EN
  logic              s1_srch, s2_srch, s3_srch;
  logic              o_srch [OUT_DELAY+1];
  logic [IDXW-1:0]   cand, trk_idx, min_idx_r;
  logic [SWIDTH-1:0] trk_sad, min_sad_r;
  logic              trk_vld, min_vld_r, better;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_srch <= 1'b0;
      s2_srch <= 1'b0;
      s3_srch <= 1'b0;
      o_srch  <= '{default: 1'b0};
    end else begin
      if (accept)
        s1_srch <= bus.srch_last;
      s2_srch   <= s1_srch;
      s3_srch   <= s2_srch;
      o_srch[0] <= s3_done && s3_srch;
      for (int i = 1; i <= OUT_DELAY; i++)
        o_srch[i] <= o_srch[i-1];
    end
  end

  // Strict less-than keeps the earliest candidate on ties.
  assign better = !trk_vld || (o_sad[OUT_DELAY] < trk_sad);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand      <= '0;
      trk_vld   <= 1'b0;
      trk_sad   <= '0;
      trk_idx   <= '0;
      min_sad_r <= '0;
      min_idx_r <= '0;
      min_vld_r <= 1'b0;
    end else begin
      min_vld_r <= 1'b0;
      if (o_vld[OUT_DELAY]) begin
        if (o_srch[OUT_DELAY]) begin
          min_vld_r <= 1'b1;
          min_sad_r <= better ? o_sad[OUT_DELAY] : trk_sad;
          min_idx_r <= better ? cand : trk_idx;
          trk_vld   <= 1'b0;
          cand      <= '0;
        end else begin
          if (better) begin
            trk_vld <= 1'b1;
            trk_sad <= o_sad[OUT_DELAY];
            trk_idx <= cand;
          end
          cand <= cand + 1'b1;
        end
      end
    end
  end

  assign bus.min_sad = min_sad_r;
  assign bus.min_idx = min_idx_r;
  assign bus.min_vld = min_vld_r;
`else
  assign bus.min_sad = '0;
  assign bus.min_idx = {IDXW{1'b0}};
  assign bus.min_vld = 1'b0;
`endif
endmodule
